// File: rtl/mips_bus_cpu_if.sv
// Avalon-MM master/slave bundle shared by instruction fetch and data access
// of the multi-cycle MIPS core.
interface mips_bus_cpu_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_cpu.sv
// Multi-cycle MIPS-I integer subset: FETCH -> EXEC -> (MEM) over one Avalon-MM
// master port, one branch delay slot, halts once a jump to address 0 retires.
module mips_bus_cpu #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic           clk,
  input  logic           reset,
  output logic           active,
  output logic [31:0]    register_v0,
  mips_bus_cpu_if.master bus
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, HALTED = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, ir_r, target_r, maddr_r, wdata_r;
  logic        in_slot_r, is_load_r;
  logic [31:0] regs_r [32];

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, sh_s, wb_idx_s;
  logic [31:0] rs_v_s, rt_v_s, simm_s, zimm_s, pc4_s, next_pc_s, ea_s;
  logic [31:0] wb_val_s, tgt_s, addr_s;
  logic        wb_en_s, is_mem_s, is_load_s, taken_s, read_s, write_s, done_s;

  assign op_s      = ir_r[31:26];
  assign rs_s      = ir_r[25:21];
  assign rt_s      = ir_r[20:16];
  assign rd_s      = ir_r[15:11];
  assign sh_s      = ir_r[10:6];
  assign funct_s   = ir_r[5:0];
  assign rs_v_s    = regs_r[rs_s];
  assign rt_v_s    = regs_r[rt_s];
  assign simm_s    = {{16{ir_r[15]}}, ir_r[15:0]};
  assign zimm_s    = {16'd0, ir_r[15:0]};
  assign pc4_s     = pc_r + 32'd4;
  assign ea_s      = rs_v_s + simm_s;
  // Completion of the delay-slot instruction redirects to the saved target.
  assign next_pc_s = in_slot_r ? target_r : pc4_s;

  // Instruction decode and ALU.
  always_comb begin
    wb_en_s   = 1'b0;
    wb_idx_s  = rt_s;
    wb_val_s  = 32'd0;
    is_mem_s  = 1'b0;
    is_load_s = 1'b0;
    taken_s   = 1'b0;
    tgt_s     = pc4_s + {simm_s[29:0], 2'b00};
    case (op_s)
      6'h00: begin
        wb_en_s  = 1'b1;
        wb_idx_s = rd_s;
        case (funct_s)
          6'h21: wb_val_s = rs_v_s + rt_v_s;
          6'h23: wb_val_s = rs_v_s - rt_v_s;
          6'h24: wb_val_s = rs_v_s & rt_v_s;
          6'h25: wb_val_s = rs_v_s | rt_v_s;
          6'h26: wb_val_s = rs_v_s ^ rt_v_s;
          6'h27: wb_val_s = ~(rs_v_s | rt_v_s);
          6'h2A: wb_val_s = {31'd0, $signed(rs_v_s) < $signed(rt_v_s)};
          6'h2B: wb_val_s = {31'd0, rs_v_s < rt_v_s};
          6'h00: wb_val_s = rt_v_s << sh_s;
          6'h02: wb_val_s = rt_v_s >> sh_s;
          6'h03: wb_val_s = $signed(rt_v_s) >>> sh_s;
          6'h04: wb_val_s = rt_v_s << rs_v_s[4:0];
          6'h06: wb_val_s = rt_v_s >> rs_v_s[4:0];
          6'h07: wb_val_s = $signed(rt_v_s) >>> rs_v_s[4:0];
          6'h08: begin wb_en_s = 1'b0; taken_s = 1'b1; tgt_s = rs_v_s; end
          6'h09: begin taken_s = 1'b1; tgt_s = rs_v_s; wb_val_s = pc4_s + 32'd4; end
          default: wb_en_s = 1'b0;
        endcase
      end
      6'h02: begin taken_s = 1'b1; tgt_s = {pc4_s[31:28], ir_r[25:0], 2'b00}; end
      6'h03: begin
        taken_s  = 1'b1;
        tgt_s    = {pc4_s[31:28], ir_r[25:0], 2'b00};
        wb_en_s  = 1'b1;
        wb_idx_s = 5'd31;
        wb_val_s = pc4_s + 32'd4;
      end
      6'h04: taken_s = (rs_v_s == rt_v_s);
      6'h05: taken_s = (rs_v_s != rt_v_s);
      6'h06: taken_s = rs_v_s[31] || (rs_v_s == 32'd0);
      6'h07: taken_s = !rs_v_s[31] && (rs_v_s != 32'd0);
      6'h09: begin wb_en_s = 1'b1; wb_val_s = rs_v_s + simm_s; end
      6'h0A: begin wb_en_s = 1'b1; wb_val_s = {31'd0, $signed(rs_v_s) < $signed(simm_s)}; end
      6'h0B: begin wb_en_s = 1'b1; wb_val_s = {31'd0, rs_v_s < simm_s}; end
      6'h0C: begin wb_en_s = 1'b1; wb_val_s = rs_v_s & zimm_s; end
      6'h0D: begin wb_en_s = 1'b1; wb_val_s = rs_v_s | zimm_s; end
      6'h0E: begin wb_en_s = 1'b1; wb_val_s = rs_v_s ^ zimm_s; end
      6'h0F: begin wb_en_s = 1'b1; wb_val_s = {ir_r[15:0], 16'd0}; end
      6'h23: begin is_mem_s = 1'b1; is_load_s = 1'b1; end
      6'h2B: is_mem_s = 1'b1;
      default: wb_en_s = 1'b0;
    endcase
  end

  // Sequencer next state and bus strobes.
  always_comb begin
    state_s = state_r;
    read_s  = 1'b0;
    write_s = 1'b0;
    addr_s  = pc_r;
    done_s  = 1'b0;
    case (state_r)
      FETCH: begin
        read_s = 1'b1;
        if (!bus.waitrequest) state_s = EXEC;
        else                  state_s = FETCH;
      end
      EXEC: begin
        if (is_mem_s) state_s = MEM;
        else          done_s  = 1'b1;
      end
      MEM: begin
        addr_s  = maddr_r;
        read_s  = is_load_r;
        write_s = !is_load_r;
        if (!bus.waitrequest) done_s = 1'b1;
        else                  done_s = 1'b0;
      end
      HALTED:  state_s = HALTED;
      default: state_s = FETCH;
    endcase
    if (done_s) state_s = (in_slot_r && target_r == 32'd0) ? HALTED : FETCH;
    else        state_s = state_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= state_s;
  end

  // Datapath: IR, PC, delay-slot tracking, memory address/data, register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= RESET_VECTOR;
      ir_r      <= 32'd0;
      target_r  <= 32'd0;
      maddr_r   <= 32'd0;
      wdata_r   <= 32'd0;
      in_slot_r <= 1'b0;
      is_load_r <= 1'b0;
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
    end else begin
      case (state_r)
        FETCH: if (!bus.waitrequest) ir_r <= bus.readdata;
        EXEC: begin
          if (wb_en_s && wb_idx_s != 5'd0) regs_r[wb_idx_s] <= wb_val_s;
          if (is_mem_s) begin
            maddr_r   <= ea_s & 32'hFFFF_FFFC;
            is_load_r <= is_load_s;
            if (!is_load_s) wdata_r <= rt_v_s;
          end else if (in_slot_r) begin
            pc_r      <= target_r;
            in_slot_r <= 1'b0;
          end else if (taken_s) begin
            pc_r      <= pc4_s;
            in_slot_r <= 1'b1;
            target_r  <= tgt_s;
          end else begin
            pc_r <= pc4_s;
          end
        end
        MEM: if (!bus.waitrequest) begin
          if (is_load_r && rt_s != 5'd0) regs_r[rt_s] <= bus.readdata;
          pc_r      <= next_pc_s;
          in_slot_r <= 1'b0;
        end
        default: pc_r <= pc_r;
      endcase
    end
  end

  // Requests are suppressed while reset is held so an aborted access never lingers.
  assign bus.address    = addr_s;
  assign bus.read       = read_s & ~reset;
  assign bus.write      = write_s & ~reset;
  assign bus.writedata  = wdata_r;
  assign bus.byteenable = 4'b1111;
  assign active         = (state_r != HALTED);
  assign register_v0    = regs_r[2];
endmodule

// File: tb/tb_mips_bus_cpu.sv
// Directed programs for mips_bus_cpu with a word memory model on the Avalon port,
// optional random wait states and hand-computed expected results.
module tb_mips_bus_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active;
  logic [31:0] v0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [3:0]  last_be = 4'd0;

  mips_bus_cpu_if bus ();

  mips_bus_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (addr[31:28] == 4'hB) return rom[addr[7:2]];
    else                     return ram[addr[7:2]];
  endfunction

  task automatic load_prog(input int n);
    for (int i = 0; i < 64; i++) begin rom[i] = 32'd0; ram[i] = 32'd0; end
    case (n)
      1: begin
        rom[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
        rom[1] = enc_i(6'h09, 5'd2, 5'd2, 16'hFFF9);
        rom[2] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      end
      2: begin
        rom[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
        rom[1] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
        rom[2] = enc_i(6'h09, 5'd0, 5'd4, 16'h1000);
        rom[3] = enc_i(6'h2B, 5'd4, 5'd3, 16'd0);
        rom[4] = enc_i(6'h23, 5'd4, 5'd2, 16'd0);
        rom[5] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      end
      3: begin
        rom[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        rom[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        rom[2] = enc_i(6'h09, 5'd2, 5'd2, 16'd10);
        rom[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      end
      4: begin
        rom[0] = {6'h03, 26'h3F0_0004};
        rom[2] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
        rom[4] = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
        rom[5] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
      end
      default: begin
        rom[0]  = enc_i(6'h09, 5'd0, 5'd4, 16'h1000);
        rom[1]  = enc_i(6'h09, 5'd0, 5'd5, 16'hFFF0);
        rom[2]  = enc_i(6'h09, 5'd0, 5'd6, 16'd3);
        rom[3]  = enc_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h23);
        rom[5]  = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h2A);
        rom[7]  = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h2B);
        rom[9]  = enc_r(5'd0, 5'd5, 5'd7, 5'd2, 6'h03);
        rom[11] = enc_r(5'd0, 5'd5, 5'd7, 5'd4, 6'h02);
        rom[13] = enc_r(5'd6, 5'd5, 5'd7, 5'd0, 6'h04);
        rom[15] = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h27);
        rom[17] = enc_i(6'h0E, 5'd5, 5'd7, 16'hFFFF);
        rom[19] = enc_i(6'h0B, 5'd6, 5'd7, 16'hFFFF);
        for (int k = 0; k < 9; k++) rom[4 + 2 * k] = enc_i(6'h2B, 5'd4, 5'd7, 16'(4 * k));
        rom[21] = enc_i(6'h05, 5'd6, 5'd0, 16'd2);
        rom[22] = enc_i(6'h09, 5'd0, 5'd8, 16'd7);
        rom[23] = enc_i(6'h09, 5'd8, 5'd8, 16'd1);
        rom[24] = enc_i(6'h07, 5'd5, 5'd0, 16'd2);
        rom[26] = enc_i(6'h09, 5'd8, 5'd8, 16'd2);
        rom[27] = enc_i(6'h2B, 5'd4, 5'd8, 16'd36);
        rom[28] = enc_i(6'h09, 5'd0, 5'd0, 16'd5);
        rom[29] = enc_i(6'h2B, 5'd4, 5'd0, 16'd40);
        rom[30] = enc_i(6'h09, 5'd0, 5'd2, 16'h0055);
        rom[31] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      end
    endcase
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.waitrequest = 1'b0;
    bus.readdata = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_count = 0;
  endtask

  // Plays the Avalon slave until the core halts; checks bus stability under stalls.
  task automatic run_prog(input int max_stall, input int budget,
                          output int cycles, output bit halted);
    int stall;
    bit stalled;
    logic [71:0] saved;
    stall = $urandom_range(max_stall, 0);
    stalled = 1'b0;
    saved = 72'd0;
    halted = 1'b0;
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      if (!active) begin
        halted = 1'b1;
      end else begin
        cycles++;
        if (stalled) begin
          checks++;
          if ({bus.address, bus.read, bus.write, bus.writedata, bus.byteenable, 2'b00} !== saved) begin
            errors++;
            $display("FAIL stall_stable: got %h expected %h",
                     {bus.address, bus.read, bus.write, bus.writedata, bus.byteenable, 2'b00}, saved);
          end
        end
        checks++;
        if ((bus.read && bus.write) !== 1'b0 || bus.address[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL bus_protocol: got rd=%b wr=%b addr=%h expected exclusive, aligned",
                   bus.read, bus.write, bus.address);
        end
        bus.readdata = bus.read ? mem_rd(bus.address) : 32'd0;
        if ((bus.read || bus.write) && stall > 0) begin
          bus.waitrequest = 1'b1;
          stall--;
          stalled = 1'b1;
          saved = {bus.address, bus.read, bus.write, bus.writedata, bus.byteenable, 2'b00};
        end else begin
          bus.waitrequest = 1'b0;
          stalled = 1'b0;
          if (bus.write) begin
            ram[bus.address[7:2]] = bus.writedata;
            wr_count++;
            last_wr_addr = bus.address;
            last_be = bus.byteenable;
          end
          if (bus.read || bus.write) stall = $urandom_range(max_stall, 0);
        end
      end
    end
    bus.waitrequest = 1'b0;
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL halt_timeout: got active=%b after %0d cycles expected halt", active, cycles);
    end
  endtask

  task automatic test_reset();
    load_prog(1);
    reset = 1'b1;
    bus.waitrequest = 1'b0;
    bus.readdata = 32'd0;
    @(posedge clk);
    #1;
    checks++; if ({bus.read, bus.write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got %b expected 00", {bus.read, bus.write}); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b expected 1", active); end
    checks++; if (v0 !== 32'd0) begin errors++; $display("FAIL reset_v0: got %h expected 0", v0); end
    checks++; if (bus.writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.writedata); end
    checks++; if (bus.byteenable !== 4'b1111) begin errors++; $display("FAIL reset_be: got %b expected 1111", bus.byteenable); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.read !== 1'b1) begin errors++; $display("FAIL first_read: got %b expected 1", bus.read); end
    checks++; if (bus.address !== 32'hBFC0_0000) begin errors++; $display("FAIL first_addr: got %h expected bfc00000", bus.address); end
    checks++; if (active !== 1'b1 || bus.write !== 1'b0) begin errors++; $display("FAIL first_active: got act=%b wr=%b expected 1 0", active, bus.write); end
  endtask

  task automatic test_arith();
    int cyc;
    bit h;
    load_prog(1);
    apply_reset();
    run_prog(0, 200, cyc, h);
    checks++; if (v0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL arith_v0: got %h expected fffffffe", v0); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL arith_cycles: got %0d expected 8", cyc); end
    repeat (5) @(negedge clk);
    checks++; if ({active, bus.read, bus.write} !== 3'b000) begin errors++; $display("FAIL halt_quiet: got %b expected 000", {active, bus.read, bus.write}); end
    checks++; if (v0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL halt_frozen: got %h expected fffffffe", v0); end
  endtask

  task automatic test_load_store();
    int cyc;
    bit h;
    load_prog(2);
    apply_reset();
    run_prog(0, 200, cyc, h);
    checks++; if (v0 !== 32'h1234_5678) begin errors++; $display("FAIL ls_v0: got %h expected 12345678", v0); end
    checks++; if (wr_count !== 1) begin errors++; $display("FAIL ls_wcount: got %0d expected 1", wr_count); end
    checks++; if (last_wr_addr !== 32'h0000_1000) begin errors++; $display("FAIL ls_waddr: got %h expected 00001000", last_wr_addr); end
    checks++; if (last_be !== 4'b1111) begin errors++; $display("FAIL ls_be: got %b expected 1111", last_be); end
    checks++; if (ram[0] !== 32'h1234_5678) begin errors++; $display("FAIL ls_mem: got %h expected 12345678", ram[0]); end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL ls_cycles: got %0d expected 16", cyc); end
  endtask

  task automatic test_delay_slot();
    int cyc;
    bit h;
    load_prog(3);
    apply_reset();
    run_prog(0, 200, cyc, h);
    checks++; if (v0 !== 32'd1) begin errors++; $display("FAIL slot_v0: got %h expected 00000001", v0); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL slot_cycles: got %0d expected 8", cyc); end
  endtask

  task automatic test_jal();
    int cyc;
    bit h;
    load_prog(4);
    apply_reset();
    run_prog(0, 200, cyc, h);
    checks++; if (v0 !== 32'hBFC0_0008) begin errors++; $display("FAIL jal_v0: got %h expected bfc00008", v0); end
    checks++; if (cyc !== 14) begin errors++; $display("FAIL jal_cycles: got %0d expected 14", cyc); end
  endtask

  task automatic test_alu();
    int cyc;
    bit h;
    logic [31:0] exp_mem [11];
    exp_mem = '{32'h0000_0013, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFC,
                32'h0FFF_FFFF, 32'hFFFF_FF80, 32'h0000_000C, 32'hFFFF_000F,
                32'h0000_0001, 32'h0000_0009, 32'h0000_0000};
    load_prog(5);
    ram[10] = 32'hFFFF_FFFF;
    apply_reset();
    run_prog(0, 400, cyc, h);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (ram[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL alu_word%0d: got %h expected %h", i, ram[i], exp_mem[i]);
      end
    end
    checks++; if (v0 !== 32'h0000_0055) begin errors++; $display("FAIL alu_v0: got %h expected 00000055", v0); end
  endtask

  task automatic test_stalls();
    int cyc;
    bit h;
    logic [31:0] exp_v0 [5];
    exp_v0 = '{32'hFFFF_FFFE, 32'h1234_5678, 32'h0000_0001, 32'hBFC0_0008, 32'h0000_0055};
    for (int p = 1; p <= 5; p++) begin
      load_prog(p);
      apply_reset();
      run_prog(3, 1000, cyc, h);
      checks++;
      if (v0 !== exp_v0[p - 1]) begin
        errors++;
        $display("FAIL stall_v0_prog%0d: got %h expected %h", p, v0, exp_v0[p - 1]);
      end
      if (p == 2) begin
        checks++;
        if (wr_count !== 1 || ram[0] !== 32'h1234_5678) begin
          errors++;
          $display("FAIL stall_store: got %0d writes data %h expected 1 writes data 12345678", wr_count, ram[0]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit h;
    load_prog(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (v0 !== 32'd0 || active !== 1'b1) begin errors++; $display("FAIL rearm: got v0=%h act=%b expected 0 1", v0, active); end
    reset = 1'b0;
    @(negedge clk);
    bus.waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.read !== 1'b1 || bus.address !== 32'hBFC0_0000) begin errors++; $display("FAIL stalled_fetch: got rd=%b addr=%h expected 1 bfc00000", bus.read, bus.address); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.waitrequest = 1'b0;
    reset = 1'b0;
    wr_count = 0;
    #1;
    checks++; if (bus.read !== 1'b1 || bus.address !== 32'hBFC0_0000) begin errors++; $display("FAIL abort_refetch: got rd=%b addr=%h expected 1 bfc00000", bus.read, bus.address); end
    run_prog(0, 200, cyc, h);
    checks++; if (v0 !== 32'h1234_5678 || wr_count !== 1) begin errors++; $display("FAIL abort_rerun: got v0=%h writes=%0d expected 12345678 1", v0, wr_count); end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL abort_cycles: got %0d expected 16", cyc); end
  endtask

  initial begin
    bus.waitrequest = 1'b0;
    bus.readdata = 32'd0;
    test_reset();
    test_arith();
    test_load_store();
    test_delay_slot();
    test_jal();
    test_alu();
    test_stalls();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
